// File: rtl/src_pkg.sv
// rtl/src_pkg.sv - shared types and constants for the source playback sequencer
// Contents:
//   state_t      sequencer state encoding, also reported in STATUS[3:0]
//   ADDR_*       register port addresses
//   CTRL_*       bit positions of the write-1 pulses in the CTRL register
//   DF_CODE_*    data_form codes understood by the source controller
//   ctrl_t       decoded, priority-resolved CTRL pulses
//   pack_status  STATUS register layout
package src_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_PRIME = 4'd2,
        ST_RUN   = 4'd3,
        ST_HALT  = 4'd4,
        ST_ERR   = 4'd5
    } state_t;

    localparam logic [2:0] ADDR_CTRL        = 3'd0;
    localparam logic [2:0] ADDR_POS_SH      = 3'd1;
    localparam logic [2:0] ADDR_NEG_SH      = 3'd2;
    localparam logic [2:0] ADDR_FORM_SH     = 3'd3;
    localparam logic [2:0] ADDR_START_LEVEL = 3'd4;
    localparam logic [2:0] ADDR_STATUS      = 3'd5;
    localparam logic [2:0] ADDR_ACTIVE_POS  = 3'd6;
    localparam logic [2:0] ADDR_ACTIVE_NEG  = 3'd7;

    localparam int CTRL_START     = 0;
    localparam int CTRL_STOP      = 1;
    localparam int CTRL_APPLY     = 2;
    localparam int CTRL_CLR_FLAGS = 3;

    localparam logic [3:0] DF_CODE_1 = 4'd1;
    localparam logic [3:0] DF_CODE_2 = 4'd2;
    localparam logic [3:0] DF_CODE_3 = 4'd3;
    localparam logic [3:0] DF_CODE_4 = 4'd4;
    localparam logic [3:0] DF_CODE_5 = 4'd5;
    localparam logic [3:0] DF_RESET  = DF_CODE_4;

    typedef struct packed {
        logic start;
        logic stop;
        logic apply;
        logic clr_flags;
    } ctrl_t;

    function automatic logic [31:0] pack_status(
        input logic [15:0] cnt,
        input logic        cfg_e,
        input logic        tmo_e,
        input logic        uf_f,
        input state_t      st
    );
        return {cnt, 9'b0, cfg_e, tmo_e, uf_f, st};
    endfunction

endpackage

// File: rtl/source_cfg_sched_if.sv
// rtl/source_cfg_sched_if.sv - host register port of the source playback sequencer
// Signals:
//   wr_en  single-cycle write strobe
//   rd_en  single-cycle read strobe
//   addr   register address
//   wdata  write data
//   rdata  read data, valid the cycle after rd_en
// Modports: master (host side), slave (sequencer side).
interface source_cfg_sched_if;

    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output wr_en,
        output rd_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/src_regfile.sv
// rtl/src_regfile.sv - shadow registers, start level, CTRL decode and read mux
// Ports:
//   clk, nRST    clock, asynchronous active-low reset
//   bus          register port (slave)
//   status       packed STATUS word from the sequencer
//   act_pos/neg  active lengths, read back at ACTIVE_POS/ACTIVE_NEG
//   pos_sh, neg_sh, form_sh, start_level   shadow values to the sequencer
//   ctrl         CTRL pulses, valid in the write cycle, STOP > APPLY > START resolved
module src_regfile
    import src_pkg::*;
#(
    parameter logic [12:0] START_LEVEL_RST = 13'd2000
) (
    input  logic                 clk,
    input  logic                 nRST,
    source_cfg_sched_if.slave    bus,
    input  logic [31:0]          status,
    input  logic [31:0]          act_pos,
    input  logic [31:0]          act_neg,
    output logic [31:0]          pos_sh,
    output logic [31:0]          neg_sh,
    output logic [3:0]           form_sh,
    output logic [12:0]          start_level,
    output ctrl_t                ctrl
);

    logic [31:0] pos_sh_q, pos_sh_d;
    logic [31:0] neg_sh_q, neg_sh_d;
    logic [3:0]  form_sh_q, form_sh_d;
    logic [12:0] start_level_q, start_level_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        pos_sh_d      = pos_sh_q;
        neg_sh_d      = neg_sh_q;
        form_sh_d     = form_sh_q;
        start_level_d = start_level_q;
        rdata_d       = '0;
        ctrl          = '0;

        if (bus.wr_en) begin
            case (bus.addr)
                ADDR_CTRL: begin
                    ctrl.stop      = bus.wdata[CTRL_STOP];
                    ctrl.apply     = bus.wdata[CTRL_APPLY] & ~bus.wdata[CTRL_STOP];
                    ctrl.start     = bus.wdata[CTRL_START] & ~bus.wdata[CTRL_STOP]
                                   & ~bus.wdata[CTRL_APPLY];
                    ctrl.clr_flags = bus.wdata[CTRL_CLR_FLAGS];
                end
                ADDR_POS_SH:      pos_sh_d      = bus.wdata;
                ADDR_NEG_SH:      neg_sh_d      = bus.wdata;
                ADDR_FORM_SH:     form_sh_d     = bus.wdata[3:0];
                ADDR_START_LEVEL: start_level_d = bus.wdata[12:0];
                default: ;
            endcase
        end

        // Mux reads the _q values so a same-cycle write is not visible yet.
        if (bus.rd_en) begin
            case (bus.addr)
                ADDR_POS_SH:      rdata_d = pos_sh_q;
                ADDR_NEG_SH:      rdata_d = neg_sh_q;
                ADDR_FORM_SH:     rdata_d = {28'b0, form_sh_q};
                ADDR_START_LEVEL: rdata_d = {19'b0, start_level_q};
                ADDR_STATUS:      rdata_d = status;
                ADDR_ACTIVE_POS:  rdata_d = act_pos;
                ADDR_ACTIVE_NEG:  rdata_d = act_neg;
                default:          rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            pos_sh_q      <= '0;
            neg_sh_q      <= '0;
            form_sh_q     <= DF_RESET;
            start_level_q <= START_LEVEL_RST;
            rdata_q       <= '0;
        end else begin
            pos_sh_q      <= pos_sh_d;
            neg_sh_q      <= neg_sh_d;
            form_sh_q     <= form_sh_d;
            start_level_q <= start_level_d;
            rdata_q       <= rdata_d;
        end
    end

    assign pos_sh      = pos_sh_q;
    assign neg_sh      = neg_sh_q;
    assign form_sh     = form_sh_q;
    assign start_level = start_level_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: rtl/source_cfg_sched.sv
// rtl/source_cfg_sched.sv - host-side sequencer for the source-output playback path
// Ports:
//   clk, nRST      clock, asynchronous active-low reset
//   bus            register port (slave), see src_pkg for the map
//   fifo_usedw     playback FIFO fill level
//   data_en_mon    source read enable, monitored for underflow
//   pos_length, neg_length, data_form   active parameters, committed only in LOAD
//   src_nrst       registered active-low reset to the source controller
//   busy           state is not IDLE
//   irq            one-cycle pulse on underflow or prime timeout
module source_cfg_sched
    import src_pkg::*;
#(
    parameter logic [12:0] START_LEVEL_RST = 13'd2000,
    parameter int          HALT_CYC        = 4,
    parameter logic [23:0] PRIME_TMO       = 24'd10_000_000,
    parameter bit          STOP_ON_UF      = 1'b1
) (
    input  logic              clk,
    input  logic              nRST,
    source_cfg_sched_if.slave bus,
    input  logic [12:0]       fifo_usedw,
    input  logic              data_en_mon,
    output logic [31:0]       pos_length,
    output logic [31:0]       neg_length,
    output logic [3:0]        data_form,
    output logic              src_nrst,
    output logic              busy,
    output logic              irq
);

    localparam logic [3:0]  HALT_LAST = 4'(HALT_CYC - 1);
    localparam logic [23:0] TMO_LAST  = PRIME_TMO - 24'd1;

    logic [31:0] pos_sh, neg_sh;
    logic [3:0]  form_sh;
    logic [12:0] start_level;
    ctrl_t       ctrl;
    logic [31:0] status;

    state_t      state_q, state_d;
    state_t      halt_tgt_q, halt_tgt_d;
    logic        load_ret_idle_q, load_ret_idle_d;
    logic [23:0] timer_q, timer_d;
    logic [3:0]  halt_cnt_q, halt_cnt_d;
    logic [15:0] uf_cnt_q, uf_cnt_d;
    logic        uf_flag_q, uf_flag_d;
    logic        tmo_err_q, tmo_err_d;
    logic        cfg_err_q, cfg_err_d;
    logic [31:0] pos_q, pos_d;
    logic [31:0] neg_q, neg_d;
    logic [3:0]  form_q, form_d;
    logic        src_nrst_q, src_nrst_d;
    logic        irq_q, irq_d;
    logic        uf;
    logic        tmo_set;
    logic        cfg_set;

    src_regfile #(
        .START_LEVEL_RST (START_LEVEL_RST)
    ) u_regfile (
        .clk         (clk),
        .nRST        (nRST),
        .bus         (bus),
        .status      (status),
        .act_pos     (pos_q),
        .act_neg     (neg_q),
        .pos_sh      (pos_sh),
        .neg_sh      (neg_sh),
        .form_sh     (form_sh),
        .start_level (start_level),
        .ctrl        (ctrl)
    );

    assign status = pack_status(uf_cnt_q, cfg_err_q, tmo_err_q, uf_flag_q, state_q);
    assign uf     = (state_q == ST_RUN) && data_en_mon && (fifo_usedw == '0);

    always_comb begin
        state_d         = state_q;
        halt_tgt_d      = halt_tgt_q;
        load_ret_idle_d = load_ret_idle_q;
        timer_d         = timer_q;
        halt_cnt_d      = halt_cnt_q;
        pos_d           = pos_q;
        neg_d           = neg_q;
        form_d          = form_q;
        tmo_set         = 1'b0;
        cfg_set         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl.apply) begin
                    state_d         = ST_LOAD;
                    load_ret_idle_d = 1'b1;
                end else if (ctrl.start) begin
                    if (pos_sh != '0) begin
                        state_d         = ST_LOAD;
                        load_ret_idle_d = 1'b0;
                    end else begin
                        cfg_set = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                pos_d   = pos_sh;
                neg_d   = neg_sh;
                form_d  = form_sh;
                timer_d = '0;
                state_d = load_ret_idle_q ? ST_IDLE : ST_PRIME;
            end
            ST_PRIME: begin
                if (ctrl.stop) begin
                    state_d    = ST_HALT;
                    halt_tgt_d = ST_IDLE;
                    halt_cnt_d = '0;
                end else if (ctrl.apply) begin
                    state_d         = ST_LOAD;
                    load_ret_idle_d = 1'b0;
                end else if (fifo_usedw >= start_level) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_ERR;
                    timer_d = '0;
                    tmo_set = 1'b1;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
            ST_RUN: begin
                if (ctrl.stop || (uf && STOP_ON_UF)) begin
                    state_d    = ST_HALT;
                    halt_tgt_d = ST_IDLE;
                    halt_cnt_d = '0;
                end else if (ctrl.apply) begin
                    // Live reconfiguration: drop the source, commit, re-prime.
                    state_d    = ST_HALT;
                    halt_tgt_d = ST_LOAD;
                    halt_cnt_d = '0;
                end
            end
            ST_HALT: begin
                if (halt_cnt_q == HALT_LAST) begin
                    state_d         = halt_tgt_q;
                    load_ret_idle_d = 1'b0;
                end else begin
                    halt_cnt_d = halt_cnt_q + 4'd1;
                end
            end
            ST_ERR: begin
                if (ctrl.stop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flags: a same-cycle event wins over CLR_FLAGS so it is never lost.
    always_comb begin
        uf_cnt_d  = uf_cnt_q;
        uf_flag_d = uf_flag_q;
        tmo_err_d = tmo_err_q;
        cfg_err_d = cfg_err_q;
        if (ctrl.clr_flags) begin
            uf_cnt_d  = uf ? 16'd1 : 16'd0;
            uf_flag_d = uf;
            tmo_err_d = tmo_set;
            cfg_err_d = cfg_set;
        end else begin
            if (uf && (uf_cnt_q != 16'hFFFF)) begin
                uf_cnt_d = uf_cnt_q + 16'd1;
            end
            uf_flag_d = uf_flag_q | uf;
            tmo_err_d = tmo_err_q | tmo_set;
            cfg_err_d = cfg_err_q | cfg_set;
        end
        irq_d = uf | tmo_set;
        // Follows the current state, so it lags state entry by one cycle.
        src_nrst_d = (state_q == ST_RUN);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q         <= ST_IDLE;
            halt_tgt_q      <= ST_IDLE;
            load_ret_idle_q <= 1'b0;
            timer_q         <= '0;
            halt_cnt_q      <= '0;
            uf_cnt_q        <= '0;
            uf_flag_q       <= 1'b0;
            tmo_err_q       <= 1'b0;
            cfg_err_q       <= 1'b0;
            pos_q           <= '0;
            neg_q           <= '0;
            form_q          <= DF_RESET;
            src_nrst_q      <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            halt_tgt_q      <= halt_tgt_d;
            load_ret_idle_q <= load_ret_idle_d;
            timer_q         <= timer_d;
            halt_cnt_q      <= halt_cnt_d;
            uf_cnt_q        <= uf_cnt_d;
            uf_flag_q       <= uf_flag_d;
            tmo_err_q       <= tmo_err_d;
            cfg_err_q       <= cfg_err_d;
            pos_q           <= pos_d;
            neg_q           <= neg_d;
            form_q          <= form_d;
            src_nrst_q      <= src_nrst_d;
            irq_q           <= irq_d;
        end
    end

    assign pos_length = pos_q;
    assign neg_length = neg_q;
    assign data_form  = form_q;
    assign src_nrst   = src_nrst_q;
    assign irq        = irq_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_source_cfg_sched.sv
// tb/tb_source_cfg_sched.sv - directed self-checking bench for source_cfg_sched
module tb_source_cfg_sched;

    logic        clk = 1'b0;
    logic        nRST;
    logic [12:0] fifo_usedw;
    logic        data_en_mon;
    logic [31:0] pos_length;
    logic [31:0] neg_length;
    logic [3:0]  data_form;
    logic        src_nrst;
    logic        busy;
    logic        irq;

    int n_cmp = 0;
    int n_mis = 0;

    source_cfg_sched_if bif();

    source_cfg_sched #(
        .START_LEVEL_RST (13'd2000),
        .HALT_CYC        (4),
        .PRIME_TMO       (24'd100),
        .STOP_ON_UF      (1'b1)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .bus         (bif),
        .fifo_usedw  (fifo_usedw),
        .data_en_mon (data_en_mon),
        .pos_length  (pos_length),
        .neg_length  (neg_length),
        .data_form   (data_form),
        .src_nrst    (src_nrst),
        .busy        (busy),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bif.wr_en = 1'b1;
        bif.addr  = a;
        bif.wdata = d;
        step(1);
        bif.wr_en = 1'b0;
        bif.wdata = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bif.rd_en = 1'b1;
        bif.addr  = a;
        step(1);
        bif.rd_en = 1'b0;
        d = bif.rdata;
    endtask

    initial begin
        logic [31:0] r;
        logic        seen_hi;
        int          halt_len;
        int          irq_cnt;
        int          cnt;

        nRST        = 1'b0;
        fifo_usedw  = '0;
        data_en_mon = 1'b0;
        bif.wr_en   = 1'b0;
        bif.rd_en   = 1'b0;
        bif.addr    = '0;
        bif.wdata   = '0;
        step(2);

        check("rst_pos", pos_length, 32'd0);
        check("rst_neg", neg_length, 32'd0);
        check("rst_form", {28'b0, data_form}, 32'd4);
        check("rst_src_nrst", {31'b0, src_nrst}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rdata", bif.rdata, 32'd0);
        nRST = 1'b1;
        step(1);
        rd(3'd4, r); check("rst_start_level", r, 32'd2000);
        rd(3'd3, r); check("rst_form_sh", r, 32'd4);
        rd(3'd5, r); check("rst_status", r, 32'd0);

        // Start and prime: level held one below threshold.
        fifo_usedw = 13'd1999;
        wr(3'd1, 32'd100);
        wr(3'd2, 32'd50);
        wr(3'd3, 32'd2);
        wr(3'd0, 32'h1);
        step(1);
        check("load_pos", pos_length, 32'd100);
        check("load_neg", neg_length, 32'd50);
        check("load_form", {28'b0, data_form}, 32'd2);
        check("prime_busy", {31'b0, busy}, 32'd1);
        seen_hi = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (src_nrst) seen_hi = 1'b1;
        end
        check("prime_hold_src_nrst", {31'b0, seen_hi}, 32'd0);
        rd(3'd5, r); check("prime_hold_state", r, 32'h2);
        fifo_usedw = 13'd2000;
        step(1); check("run_entry_src_nrst", {31'b0, src_nrst}, 32'd0);
        step(1); check("run_src_nrst", {31'b0, src_nrst}, 32'd1);
        rd(3'd5, r); check("run_state", r, 32'h3);

        // Underflow in RUN halts to IDLE.
        data_en_mon = 1'b1;
        fifo_usedw  = 13'd0;
        step(1);
        data_en_mon = 1'b0;
        fifo_usedw  = 13'd2000;
        irq_cnt  = int'(irq);
        halt_len = 0;
        while (busy && halt_len < 20) begin
            halt_len++;
            step(1);
            irq_cnt += int'(irq);
        end
        check("uf_halt_len", halt_len, 32'd4);
        check("uf_irq_pulses", irq_cnt, 32'd1);
        check("uf_src_nrst", {31'b0, src_nrst}, 32'd0);
        rd(3'd5, r); check("uf_status", r, 32'h0001_0010);

        // Live reconfiguration through HALT -> LOAD -> PRIME.
        wr(3'd0, 32'h1);
        step(3);
        check("restart_src_nrst", {31'b0, src_nrst}, 32'd1);
        fifo_usedw = 13'd0;
        wr(3'd1, 32'd7);
        wr(3'd0, 32'h4);
        check("halt_pos_hold", pos_length, 32'd100);
        step(3);
        check("halt_end_pos", pos_length, 32'd100);
        check("halt_end_busy", {31'b0, busy}, 32'd1);
        check("halt_end_src_nrst", {31'b0, src_nrst}, 32'd0);
        step(2);
        check("reload_pos", pos_length, 32'd7);
        rd(3'd5, r); check("reprime_status", r, 32'h0001_0012);
        wr(3'd0, 32'h2);
        step(5);
        rd(3'd5, r); check("stop_prime_status", r, 32'h0001_0010);

        // Clear flags.
        wr(3'd0, 32'h8);
        rd(3'd5, r); check("clr_status", r, 32'h0);

        // START with zero positive length.
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h1);
        check("cfg_busy", {31'b0, busy}, 32'd0);
        rd(3'd5, r); check("cfg_status", r, 32'h40);
        check("cfg_src_nrst", {31'b0, src_nrst}, 32'd0);
        wr(3'd0, 32'h8);

        // Prime timeout: 1 LOAD cycle + 100 PRIME cycles.
        wr(3'd1, 32'd5);
        fifo_usedw = 13'd0;
        wr(3'd0, 32'h1);
        cnt = 0;
        while (!irq && cnt < 200) begin
            step(1);
            cnt++;
        end
        check("tmo_cycles", cnt, 32'd101);
        step(1);
        check("tmo_irq_single", {31'b0, irq}, 32'd0);
        rd(3'd5, r); check("tmo_status", r, 32'h25);
        wr(3'd0, 32'h1);
        rd(3'd5, r); check("err_start_ignored", r, 32'h25);
        wr(3'd0, 32'h2);
        rd(3'd5, r); check("err_stop_status", r, 32'h20);
        check("err_stop_busy", {31'b0, busy}, 32'd0);

        // START|STOP in IDLE: STOP wins.
        wr(3'd0, 32'h8);
        wr(3'd0, 32'h3);
        check("ss_busy", {31'b0, busy}, 32'd0);
        rd(3'd5, r); check("ss_status", r, 32'h0);

        // Same-cycle read and write returns the old value.
        bif.wr_en = 1'b1;
        bif.rd_en = 1'b1;
        bif.addr  = 3'd1;
        bif.wdata = 32'd9;
        step(1);
        bif.wr_en = 1'b0;
        bif.rd_en = 1'b0;
        check("rw_old", bif.rdata, 32'd5);
        rd(3'd1, r); check("rw_new", r, 32'd9);

        // APPLY in IDLE commits without starting, zero POS allowed.
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd33);
        wr(3'd3, 32'd5);
        wr(3'd0, 32'h4);
        step(1);
        check("apply_pos", pos_length, 32'd0);
        check("apply_neg", neg_length, 32'd33);
        check("apply_form", {28'b0, data_form}, 32'd5);
        check("apply_busy", {31'b0, busy}, 32'd0);
        rd(3'd7, r); check("apply_rd_neg", r, 32'd33);

        // Asynchronous reset in RUN.
        wr(3'd1, 32'd11);
        wr(3'd4, 32'd100);
        fifo_usedw = 13'd2000;
        wr(3'd0, 32'h1);
        step(3);
        check("run2_src_nrst", {31'b0, src_nrst}, 32'd1);
        rd(3'd6, r); check("run2_rd_pos", r, 32'd11);
        nRST = 1'b0;
        #1;
        check("arst_pos", pos_length, 32'd0);
        check("arst_neg", neg_length, 32'd0);
        check("arst_form", {28'b0, data_form}, 32'd4);
        check("arst_src_nrst", {31'b0, src_nrst}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_rdata", bif.rdata, 32'd0);
        nRST = 1'b1;
        step(1);
        rd(3'd4, r); check("arst_start_level", r, 32'd2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
